// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction-fetch block:
//                fetch FSM state encoding, instruction size and the
//                64-bit fetched-instruction entry {pc, instr}.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Fetch FSM states (explicit 2-bit encoding)
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    // Bytes per instruction word; sequential PC step
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    // One buffered fetch result
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Small synchronous FIFO holding fetched {pc, instr} entries.
//                Flush empties it in one edge. Head data reads as zero
//                when the FIFO is empty.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                push_i/push_data_i - write one entry
//                pop_i           - remove the head entry
//                flush_i         - discard all entries
//                count_o         - number of valid entries
//                full_o/empty_o  - occupancy flags
//                head_o          - oldest entry
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push_i,
    input  fetch_entry_t                  push_data_i,
    input  logic                          pop_i,
    input  logic                          flush_i,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          full_o,
    output logic                          empty_o,
    output fetch_entry_t                  head_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_DEPTH   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] c_PTR_ONE = PTR_W'(1);

    fetch_entry_t       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;

    // Simultaneous push and pop leaves the occupancy unchanged
    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + c_CNT_ONE;
        end else if (pop_i && !push_i) begin
            count_d = count_q - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
            end
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign count_o = count_q;
    assign full_o  = (count_q == c_DEPTH);
    assign empty_o = (count_q == '0);
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch
//  Description : Instruction fetch stage. Issues one memory request at a
//                time, buffers results in fetch_fifo for decode, computes
//                the next PC and handles branch/jump redirects (flushing
//                buffered and in-flight instructions).
//  Ports       : clk, rst               - clock, synchronous active-high reset
//                pc_in / pc_next        - PC register output / next value
//                imem_req/addr/ack/rdata- instruction memory handshake
//                redirect_valid/addr    - one-cycle redirect request
//                if_valid/if_instr/if_pc- FIFO head presented to decode
//                id_ready               - decode accepts the head
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h00000000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e       state_q;
    fetch_state_e       state_d;
    logic [31:0]        req_addr_q;
    logic [31:0]        req_addr_d;

    logic               w_push;
    logic               w_pop;
    logic               w_flush;
    logic               w_full;
    logic               w_empty;
    logic [CNT_W-1:0]   w_count;
    fetch_entry_t       w_push_data;
    fetch_entry_t       w_head;
    logic [31:0]        w_redirect_pc;
    logic               w_unused;

    // Redirect targets are forced to word alignment; the low bits are dropped
    assign w_redirect_pc = {redirect_addr[31:2], 2'b00};
    assign w_unused      = ^redirect_addr[1:0];

    assign w_push_data = {req_addr_q, imem_rdata};

    // Outputs are forced quiet during reset regardless of stored contents
    assign if_valid = !rst && (w_count != '0);
    assign if_instr = rst ? 32'h0 : w_head.instr;
    assign if_pc    = rst ? 32'h0 : w_head.pc;
    assign w_pop    = !w_empty && if_valid && id_ready && !redirect_valid;

    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        pc_next    = pc_in;
        imem_req   = 1'b0;
        imem_addr  = req_addr_q;
        w_push     = 1'b0;
        w_flush    = 1'b0;

        if (rst) begin
            pc_next = RESET_PC;
            state_d = IDLE;
        end else begin
            if (redirect_valid) begin
                pc_next = w_redirect_pc;
                w_flush = 1'b1;
            end

            case (state_q)
                IDLE: begin
                    // Gate on the pre-pop occupancy so a full FIFO never
                    // gains a request, even while decode drains it
                    if (!redirect_valid && !w_full) begin
                        imem_req   = 1'b1;
                        imem_addr  = pc_in;
                        req_addr_d = pc_in;
                        pc_next    = pc_in + INSTR_BYTES;
                        state_d    = WAIT;
                    end
                end
                WAIT: begin
                    imem_req = 1'b1;
                    if (redirect_valid) begin
                        // Stale response: drop it now, or wait it out
                        state_d = imem_ack ? IDLE : DISCARD;
                    end else if (imem_ack) begin
                        w_push  = 1'b1;
                        state_d = IDLE;
                    end
                end
                DISCARD: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
        end
    end

    fetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (w_push),
        .push_data_i (w_push_data),
        .pop_i       (w_pop),
        .flush_i     (w_flush),
        .count_o     (w_count),
        .full_o      (w_full),
        .empty_o     (w_empty),
        .head_o      (w_head)
    );

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_fetch
//  Description : Self-checking bench for instruction_fetch. A PC register
//                and an instruction memory surround the DUT; a scoreboard
//                queue holds the program-order addresses decode should see.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h00000000;
    localparam logic [31:0] XOR_K  = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_in = RST_PC;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = 32'h0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready = 1'b0;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [31:0] sb_q [$];
    logic [31:0] acc_log [$];
    logic [31:0] model_pc  = RST_PC;
    logic [31:0] pc_next_s = RST_PC;

    bit          mem_auto = 1'b1;
    bit          rand_lat = 1'b0;
    int          mem_cnt  = 0;
    int          mem_lat  = 1;

    instruction_fetch #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .pc_next        (pc_next),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .id_ready       (id_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_wait(input string name);
        for (int i = 0; i < 50; i++) begin
            if (dut.state_q == WAIT) break;
            tick();
        end
        check({name, "_reach_wait"}, 32'(dut.state_q == WAIT), 32'd1);
    endtask

    // PC register: captures pc_next at every rising edge
    initial forever begin
        @(posedge clk);
        #1;
        pc_in = pc_next_s;
    end

    // Instruction memory: ack mem_lat cycles after the request appears
    initial forever begin
        @(posedge clk);
        #2;
        if (mem_auto) begin
            if (imem_ack) begin
                imem_ack = 1'b0;
                mem_cnt  = imem_req ? 1 : 0;
            end else if (imem_req) begin
                mem_cnt++;
                if (mem_cnt > mem_lat) begin
                    imem_ack   = 1'b1;
                    imem_rdata = imem_addr ^ XOR_K;
                    mem_cnt    = 0;
                    mem_lat    = rand_lat ? int'($urandom_range(1, 3)) : 1;
                end
            end else begin
                mem_cnt = 0;
            end
        end
    end

    // Scoreboard monitor: decides what the coming edge does to the stream
    initial forever begin
        logic [31:0] exp_pc;
        @(negedge clk);
        pc_next_s = pc_next;
        if (rst) begin
            sb_q.delete();
            model_pc = RST_PC;
        end else if (redirect_valid) begin
            sb_q.delete();
            model_pc = redirect_addr & ~32'd3;
        end else if (if_valid && id_ready) begin
            while (sb_q.size() < 4) begin
                sb_q.push_back(model_pc);
                model_pc = model_pc + 32'd4;
            end
            exp_pc = sb_q.pop_front();
            check("head_pc", if_pc, exp_pc);
            check("head_instr", if_instr, exp_pc ^ XOR_K);
            acc_log.push_back(if_pc);
        end
        while (sb_q.size() < 4) begin
            sb_q.push_back(model_pc);
            model_pc = model_pc + 32'd4;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        bit found;

        // Reset state
        rst = 1'b1; id_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_pc_next",  pc_next,  RST_PC);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_instr", if_instr, 32'd0);
        check("rst_if_pc",    if_pc,    32'd0);
        tick();
        rst = 1'b0;

        // Sequential fetch 0, 4, 8
        for (int i = 0; i < 40; i++) begin
            if (acc_log.size() >= 3) break;
            tick();
        end
        check("s1_accepts", 32'(acc_log.size() >= 3), 32'd1);
        if (acc_log.size() >= 3) begin
            check("s1_pc0", acc_log[0], 32'h0);
            check("s1_pc1", acc_log[1], 32'h4);
            check("s1_pc2", acc_log[2], 32'h8);
        end

        // Decode stall for 10 cycles
        tick();
        id_ready = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        check("s2_count",    32'(dut.u_fifo.count_o), 32'd2);
        check("s2_no_req",   32'(imem_req), 32'd0);
        check("s2_if_valid", 32'(if_valid), 32'd1);
        tick();
        id_ready = 1'b1;
        repeat (20) tick();

        // Randomized traffic
        rand_lat = 1'b1;
        for (int i = 0; i < 800; i++) begin
            tick();
            id_ready       = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 99) < 4);
            redirect_addr  = $urandom();
        end
        tick();
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        rand_lat       = 1'b0;
        repeat (30) tick();

        // Redirect in WAIT, stale ack three cycles later
        tick();
        mem_auto = 1'b0; imem_ack = 1'b0;
        wait_wait("s4");
        a = imem_addr;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h00000103;
        @(negedge clk);
        check("s4_pc_next", pc_next, 32'h00000100);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("s4_flushed",      32'(if_valid), 32'd0);
        check("s4_discard_req",  32'(imem_req), 32'd1);
        check("s4_discard_addr", imem_addr, a);
        tick();
        tick();
        imem_ack   = 1'b1;
        imem_rdata = a ^ XOR_K;
        tick();
        imem_ack = 1'b0;
        mem_cnt  = 0;
        mem_auto = 1'b1;
        @(negedge clk);
        check("s4_next_req",  32'(imem_req), 32'd1);
        check("s4_next_addr", imem_addr, 32'h00000100);
        check("s4_dropped",   32'(if_valid), 32'd0);
        repeat (10) tick();

        // Redirect in the same cycle as ack
        tick();
        mem_auto = 1'b0; imem_ack = 1'b0;
        wait_wait("s5");
        imem_ack       = 1'b1;
        imem_rdata     = imem_addr ^ XOR_K;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h00000200;
        @(negedge clk);
        check("s5_pc_next", pc_next, 32'h00000200);
        tick();
        imem_ack       = 1'b0;
        redirect_valid = 1'b0;
        mem_cnt        = 0;
        mem_auto       = 1'b1;
        @(negedge clk);
        check("s5_state_idle", 32'(dut.state_q == IDLE), 32'd1);
        check("s5_req_addr",   imem_addr, 32'h00000200);
        check("s5_dropped",    32'(if_valid), 32'd0);
        repeat (10) tick();

        // PC wrap at the top of the address space
        tick();
        redirect_valid = 1'b1;
        redirect_addr  = 32'hFFFFFFFE;
        tick();
        redirect_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (pc_in == 32'hFFFFFFFC && imem_req && imem_addr == 32'hFFFFFFFC) begin
                check("s6_wrap_pc_next", pc_next, 32'h00000000);
                found = 1'b1;
                break;
            end
            tick();
        end
        check("s6_wrap_seen", 32'(found), 32'd1);
        repeat (15) tick();

        // Reset while waiting on memory, late ack ignored
        tick();
        mem_auto = 1'b0; imem_ack = 1'b0;
        wait_wait("s7");
        rst = 1'b1;
        @(negedge clk);
        check("s7_rst_req",      32'(imem_req), 32'd0);
        check("s7_rst_if_valid", 32'(if_valid), 32'd0);
        check("s7_rst_pc_next",  pc_next, RST_PC);
        tick();
        rst        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        check("s7_issue_addr", imem_addr, RST_PC);
        tick();
        imem_ack = 1'b0;
        mem_cnt  = 1;
        mem_auto = 1'b1;
        @(negedge clk);
        check("s7_late_ack_ignored", 32'(if_valid), 32'd0);
        check("s7_still_wait", 32'(dut.state_q == WAIT), 32'd1);
        repeat (15) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
